// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding and line levels for the serial transmitter
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/serial_tx_baud_tick.sv
// rtl/serial_tx_baud_tick.sv - bit-period counter with synchronous clear and terminal-count tick
module baud_tick #(
    parameter int BAUD_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == CW'(BAUD_DIV - 1));

    // Wrapping on the tick means every state entered on a tick starts from zero.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - UART-style serial transmitter; SERIAL_TX_PARITY_EN adds an even-parity bit
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int BAUD_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tick;
    logic              baud_clr;
`ifdef SERIAL_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    assign baud_clr = (state_q == ST_IDLE);

    baud_tick #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud_tick (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (baud_clr),
        .tick_o(tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        done_d  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_START;
                    shift_d = data;
                    bit_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
                    par_d   = ^data;
`endif
                end
            end
            ST_START: begin
                if (tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_q == BW'(DATA_W - 1)) begin
                        bit_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        busy_d = (state_d != ST_IDLE);
        unique case (state_d)
            ST_START:  tx_d = START_LEVEL;
            ST_DATA:   tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            ST_STOP:   tx_d = STOP_LEVEL;
            default:   tx_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
